// File: rtl/iq_integrator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// iq_integrator : triggered, gated I/Q demodulating integrator
//   Define IQ_INTEGRATOR_SATURATE_EN to clamp 32-bit results (else wrap)
//   Revision 1.0
// ---------------------------------------------------------------------------
module iq_integrator #(
   parameter int SAMPLE_W = 16,
   parameter int ACC_W    = 48,
   parameter int SHIFT    = 16
) (
   input  logic                       clk100,
   input  logic                       system_reset,
   input  logic                       trigger,
   input  logic                       adc_valid,
   input  logic signed [SAMPLE_W-1:0] adc_sample,
   input  logic signed [SAMPLE_W-1:0] ref_cos,
   input  logic signed [SAMPLE_W-1:0] ref_sin,
   input  logic [15:0]                delay_len,
   input  logic [15:0]                integ_len,
   output logic                       data_valid,
   output logic signed [31:0]         i_val,
   output logic signed [31:0]         q_val,
   output logic                       busy,
   output logic                       sat
);

   localparam int PROD_W = 2 * SAMPLE_W;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_DELAY     = 3'd1,
      S_INTEGRATE = 3'd2,
      S_DRAIN     = 3'd3,
      S_OUTPUT    = 3'd4
   } state_t;

   state_t r_state, w_next;

   logic [15:0]               r_delay_len, r_integ_len, r_cnt;
   logic signed [PROD_W-1:0]  r_prod_i, r_prod_q;
   logic                      r_p_vld;
   logic signed [ACC_W-1:0]   r_acc_i, r_acc_q;
   logic                      r_dv;
   logic signed [31:0]        r_i_val, r_q_val;

   logic [16:0]               w_cnt_inc, w_integ_eff;
   logic                      w_dly_done, w_int_done, w_accept, w_start;
   logic signed [PROD_W-1:0]  w_s_ext, w_c_ext, w_n_ext;
   logic signed [ACC_W-1:0]   w_sh_i, w_sh_q;
   logic signed [31:0]        w_nar_i, w_nar_q;

   assign w_cnt_inc   = {1'b0, r_cnt} + 17'd1;
   assign w_integ_eff = (r_integ_len == 16'd0) ? 17'd1 : {1'b0, r_integ_len};
   assign w_dly_done  = adc_valid && (w_cnt_inc == {1'b0, r_delay_len});
   assign w_int_done  = adc_valid && (w_cnt_inc == w_integ_eff);
   assign w_accept    = (r_state == S_INTEGRATE) && adc_valid;
   assign w_start     = (r_state == S_IDLE) && trigger;

   assign w_s_ext = PROD_W'(adc_sample);
   assign w_c_ext = PROD_W'(ref_cos);
   assign w_n_ext = PROD_W'(ref_sin);

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:      if (trigger) w_next = (delay_len == 16'd0) ? S_INTEGRATE : S_DELAY;
         S_DELAY:     if (w_dly_done) w_next = S_INTEGRATE;
         S_INTEGRATE: if (w_int_done) w_next = S_DRAIN;
         // Wait until the last registered product has been folded into the sums.
         S_DRAIN:     if (!r_p_vld) w_next = S_OUTPUT;
         S_OUTPUT:    w_next = S_IDLE;
         default:     w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk100 or negedge system_reset) begin
      if (!system_reset) begin
         r_state     <= S_IDLE;
         r_delay_len <= '0;
         r_integ_len <= '0;
         r_cnt       <= '0;
      end else begin
         r_state <= w_next;
         if (w_start) begin
            r_delay_len <= delay_len;
            r_integ_len <= integ_len;
            r_cnt       <= '0;
         end else if (r_state == S_DELAY && adc_valid) begin
            r_cnt <= w_dly_done ? 16'd0 : w_cnt_inc[15:0];
         end else if (w_accept) begin
            r_cnt <= w_int_done ? 16'd0 : w_cnt_inc[15:0];
         end
      end
   end

   always_ff @(posedge clk100 or negedge system_reset) begin
      if (!system_reset) begin
         r_prod_i <= '0;
         r_prod_q <= '0;
         r_p_vld  <= 1'b0;
         r_acc_i  <= '0;
         r_acc_q  <= '0;
      end else begin
         r_p_vld <= w_accept;
         if (w_accept) begin
            r_prod_i <= w_s_ext * w_c_ext;
            r_prod_q <= w_s_ext * w_n_ext;
         end
         if (w_start) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
         end else if (r_p_vld) begin
            r_acc_i <= r_acc_i + ACC_W'(r_prod_i);
            r_acc_q <= r_acc_q + ACC_W'(r_prod_q);
         end
      end
   end

   assign w_sh_i = r_acc_i >>> SHIFT;
   assign w_sh_q = r_acc_q >>> SHIFT;

`ifdef IQ_INTEGRATOR_SATURATE_EN
   localparam logic signed [ACC_W-1:0] c_SAT_MAX = ACC_W'(64'sd2147483647);
   localparam logic signed [ACC_W-1:0] c_SAT_MIN = ACC_W'(-64'sd2147483648);

   logic w_hi_i, w_lo_i, w_hi_q, w_lo_q;
   logic r_sat;

   assign w_hi_i  = w_sh_i > c_SAT_MAX;
   assign w_lo_i  = w_sh_i < c_SAT_MIN;
   assign w_hi_q  = w_sh_q > c_SAT_MAX;
   assign w_lo_q  = w_sh_q < c_SAT_MIN;
   assign w_nar_i = w_hi_i ? 32'sh7FFF_FFFF : (w_lo_i ? 32'sh8000_0000 : w_sh_i[31:0]);
   assign w_nar_q = w_hi_q ? 32'sh7FFF_FFFF : (w_lo_q ? 32'sh8000_0000 : w_sh_q[31:0]);

   always_ff @(posedge clk100 or negedge system_reset) begin
      if (!system_reset) begin
         r_sat <= 1'b0;
      end else if (r_state == S_OUTPUT) begin
         r_sat <= w_hi_i | w_lo_i | w_hi_q | w_lo_q;
      end
   end

   assign sat = r_sat;
`else
   logic w_unused_hi;

   assign w_nar_i     = w_sh_i[31:0];
   assign w_nar_q     = w_sh_q[31:0];
   assign w_unused_hi = ^{w_sh_i[ACC_W-1:32], w_sh_q[ACC_W-1:32]};
   assign sat         = 1'b0;
`endif

   always_ff @(posedge clk100 or negedge system_reset) begin
      if (!system_reset) begin
         r_dv    <= 1'b0;
         r_i_val <= '0;
         r_q_val <= '0;
      end else begin
         r_dv <= (r_state == S_OUTPUT);
         if (r_state == S_OUTPUT) begin
            r_i_val <= w_nar_i;
            r_q_val <= w_nar_q;
         end
      end
   end

   assign data_valid = r_dv;
   assign i_val      = r_i_val;
   assign q_val      = r_q_val;
   assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_iq_integrator.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_iq_integrator : randomized self-checking bench for iq_integrator
//   Revision 1.0
// ---------------------------------------------------------------------------
module tb_iq_integrator;

   localparam int SHIFT_A = 16;

   logic clk100 = 1'b0;
   always #5 clk100 = ~clk100;

   int cyc = 0;
   always @(posedge clk100) cyc <= cyc + 1;

   logic               system_reset, trigger, adc_valid;
   logic signed [15:0] adc_sample, ref_cos, ref_sin;
   logic [15:0]        delay_len, integ_len;

   logic               data_valid, busy, sat;
   logic signed [31:0] i_val, q_val;
   logic               dv0, busy0, sat0;
   logic signed [31:0] i0, q0;

   int n_tests = 0;
   int n_fail  = 0;

   iq_integrator #(.SAMPLE_W(16), .ACC_W(48), .SHIFT(SHIFT_A)) dut (
      .clk100(clk100), .system_reset(system_reset), .trigger(trigger),
      .adc_valid(adc_valid), .adc_sample(adc_sample), .ref_cos(ref_cos),
      .ref_sin(ref_sin), .delay_len(delay_len), .integ_len(integ_len),
      .data_valid(data_valid), .i_val(i_val), .q_val(q_val),
      .busy(busy), .sat(sat)
   );

   iq_integrator #(.SAMPLE_W(16), .ACC_W(48), .SHIFT(0)) dut0 (
      .clk100(clk100), .system_reset(system_reset), .trigger(trigger),
      .adc_valid(adc_valid), .adc_sample(adc_sample), .ref_cos(ref_cos),
      .ref_sin(ref_sin), .delay_len(delay_len), .integ_len(integ_len),
      .data_valid(dv0), .i_val(i0), .q_val(q0),
      .busy(busy0), .sat(sat0)
   );

   // Reference narrowing of an already shifted sum to the 32-bit result.
   function automatic logic [31:0] exp_narrow(input longint v);
`ifdef IQ_INTEGRATOR_SATURATE_EN
      if (v > 64'sd2147483647)  return 32'h7FFF_FFFF;
      if (v < -64'sd2147483648) return 32'h8000_0000;
`endif
      return v[31:0];
   endfunction

   function automatic logic exp_sat(input longint vi, input longint vq);
`ifdef IQ_INTEGRATOR_SATURATE_EN
      return (vi > 64'sd2147483647) || (vi < -64'sd2147483648) ||
             (vq > 64'sd2147483647) || (vq < -64'sd2147483648);
`else
      return 1'b0;
`endif
   endfunction

   task automatic step();
      @(posedge clk100);
      #1;
   endtask

   // Drives one triggered readout on the SHIFT_A instance.
   // vmode: 0 continuous, 1 alternating, 2 random adc_valid.
   // dmode: 0 fixed 1000/16384/0, 1 same but first 3 valid samples 30000, 2 random.
   // retrig_at: >=0 extra trigger at that cycle, -2 trigger during the OUTPUT cycle.
   task automatic run_case(input string nm, input int dly, input int integ,
                           input int vmode, input int dmode, input int retrig_at);
      int n_eff, need, got, k_last, seen, first_cyc;
      longint si, sq, ls, ei, eq;
      logic v;
      logic signed [15:0] s, c, n;
      logic signed [31:0] cap_i, cap_q;
      logic cap_sat, cap_busy;
      n_eff = (integ == 0) ? 1 : integ;
      need  = dly + n_eff;
      si = 0; sq = 0; got = 0; seen = 0; first_cyc = -1; k_last = 0;
      cap_i = '0; cap_q = '0; cap_sat = 1'b0; cap_busy = 1'b0;
      delay_len = 16'(dly);
      integ_len = 16'(integ);
      trigger   = 1'b1;
      adc_valid = 1'b0;
      step();
      trigger = 1'b0;
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL %s busy_after_trigger got=%b want=1", nm, busy);
      end
      for (int t = 0; t < 4 * need + 40; t++) begin
         if (got == need && cyc >= k_last + 8) break;
         case (vmode)
            0:       v = 1'b1;
            1:       v = t[0];
            default: v = 1'($urandom_range(0, 1));
         endcase
         if (dmode == 2 || got == need) begin
            s = 16'($urandom); c = 16'($urandom); n = 16'($urandom);
         end else begin
            s = (dmode == 1 && got < 3) ? 16'sd30000 : 16'sd1000;
            c = 16'sd16384;
            n = 16'sd0;
         end
         trigger = (t == retrig_at) ||
                   (retrig_at == -2 && got == need && cyc == k_last + 2);
         adc_valid = v; adc_sample = s; ref_cos = c; ref_sin = n;
         if (v && got < need) begin
            if (got >= dly) begin
               ls = s;
               si += ls * c;
               sq += ls * n;
            end
            got++;
            if (got == need) k_last = cyc + 1;
         end
         step();
         if (data_valid === 1'b1) begin
            seen++;
            if (first_cyc < 0) begin
               first_cyc = cyc; cap_i = i_val; cap_q = q_val;
               cap_sat = sat; cap_busy = busy;
            end
         end
      end
      trigger = 1'b0;
      adc_valid = 1'b0;
      ei = si >>> SHIFT_A;
      eq = sq >>> SHIFT_A;
      n_tests++;
      if (got != need) begin
         n_fail++;
         $display("FAIL %s feed_timeout samples=%0d want=%0d", nm, got, need);
      end
      n_tests++;
      if (seen != 1) begin
         n_fail++;
         $display("FAIL %s pulse_count got=%0d want=1", nm, seen);
      end
      n_tests++;
      if (first_cyc != k_last + 3) begin
         n_fail++;
         $display("FAIL %s pulse_edge got=%0d want=%0d", nm, first_cyc, k_last + 3);
      end
      n_tests++;
      if (cap_i !== exp_narrow(ei)) begin
         n_fail++;
         $display("FAIL %s i_val got=%0d want=%0d", nm, cap_i, $signed(exp_narrow(ei)));
      end
      n_tests++;
      if (cap_q !== exp_narrow(eq)) begin
         n_fail++;
         $display("FAIL %s q_val got=%0d want=%0d", nm, cap_q, $signed(exp_narrow(eq)));
      end
      n_tests++;
      if (cap_sat !== exp_sat(ei, eq)) begin
         n_fail++;
         $display("FAIL %s sat got=%b want=%b", nm, cap_sat, exp_sat(ei, eq));
      end
      n_tests++;
      if (cap_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s busy_at_pulse got=%b want=0", nm, cap_busy);
      end
   endtask

   task automatic test_reset();
      system_reset = 1'b0;
      trigger = 1'b1; adc_valid = 1'b1;
      adc_sample = 16'sd1000; ref_cos = 16'sd16384; ref_sin = 16'sd0;
      delay_len = 16'd0; integ_len = 16'd1;
      repeat (3) step();
      n_tests++;
      if ({data_valid, busy, sat} !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_flags got=%b want=000", {data_valid, busy, sat});
      end
      n_tests++;
      if (i_val !== 32'sd0 || q_val !== 32'sd0) begin
         n_fail++;
         $display("FAIL reset_values got=%0d/%0d want=0/0", i_val, q_val);
      end
      trigger = 1'b0; adc_valid = 1'b0;
      system_reset = 1'b1;
      repeat (2) step();
      n_tests++;
      if (busy !== 1'b0 || data_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release got=%b%b want=00", busy, data_valid);
      end
   endtask

   task automatic test_basic();
      run_case("basic", 0, 4, 0, 0, -1);
      n_tests++;
      if (i_val !== 32'sd1000 || q_val !== 32'sd0 || sat !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_hold got=%0d/%0d/%b want=1000/0/0", i_val, q_val, sat);
      end
   endtask

   task automatic test_delay();
      run_case("delay", 3, 4, 1, 1, -1);
      n_tests++;
      if (i_val !== 32'sd1000) begin
         n_fail++;
         $display("FAIL delay_excluded got=%0d want=1000", i_val);
      end
   endtask

   task automatic test_retrigger();
      run_case("retrigger", 0, 4, 0, 0, 2);
      n_tests++;
      if (i_val !== 32'sd1000) begin
         n_fail++;
         $display("FAIL retrigger_value got=%0d want=1000", i_val);
      end
   endtask

   task automatic test_back_to_back();
      run_case("output_trig", 2, 3, 2, 2, -2);
      run_case("b2b_next", 1, 5, 0, 2, -1);
   endtask

   task automatic test_integ_zero();
      run_case("integ_zero", 0, 0, 0, 0, -1);
      n_tests++;
      if (i_val !== 32'sd250 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL integ_zero_value got=%0d busy=%b want=250 busy=0", i_val, busy);
      end
   endtask

   task automatic test_abort();
      int pulses;
      pulses = 0;
      delay_len = 16'd0; integ_len = 16'd4;
      adc_sample = 16'sd1000; ref_cos = 16'sd16384; ref_sin = 16'sd0;
      trigger = 1'b1; adc_valid = 1'b0;
      step();
      trigger = 1'b0; adc_valid = 1'b1;
      repeat (2) step();
      adc_valid = 1'b0;
      system_reset = 1'b0;
      #1;
      n_tests++;
      if (busy !== 1'b0 || data_valid !== 1'b0 || i_val !== 32'sd0) begin
         n_fail++;
         $display("FAIL abort_reset got busy=%b dv=%b i=%0d want 0/0/0", busy, data_valid, i_val);
      end
      repeat (2) step();
      system_reset = 1'b1;
      adc_valid = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         if (data_valid === 1'b1) pulses++;
      end
      adc_valid = 1'b0;
      n_tests++;
      if (pulses != 0) begin
         n_fail++;
         $display("FAIL abort_no_pulse got=%0d want=0", pulses);
      end
      run_case("after_abort", 0, 4, 0, 0, -1);
      n_tests++;
      if (i_val !== 32'sd1000) begin
         n_fail++;
         $display("FAIL after_abort_value got=%0d want=1000", i_val);
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 8; k++) begin
         run_case("random", int'($urandom_range(0, 5)), int'($urandom_range(0, 8)), 2, 2, -1);
      end
   endtask

   // Full-length integration with extreme operands on the SHIFT=0 instance.
   task automatic test_saturate();
      longint si, sq;
      int seen, t;
      si = 64'sd65535 * 64'sd32767 * 64'sd32767;
      sq = 64'sd65535 * 64'sd32767 * -64'sd32768;
      seen = 0;
      delay_len = 16'd0; integ_len = 16'd65535;
      adc_sample = 16'sd32767; ref_cos = 16'sd32767; ref_sin = -16'sd32768;
      trigger = 1'b1; adc_valid = 1'b0;
      step();
      trigger = 1'b0; adc_valid = 1'b1;
      for (t = 0; t < 65535 + 40; t++) begin
         step();
         if (dv0 === 1'b1) begin
            seen++;
            break;
         end
      end
      adc_valid = 1'b0;
      n_tests++;
      if (seen != 1) begin
         n_fail++;
         $display("FAIL sat_pulse_timeout got=%0d want=1", seen);
      end
      n_tests++;
      if (t != 65535 + 2) begin
         n_fail++;
         $display("FAIL sat_pulse_edge got=%0d want=%0d", t, 65535 + 2);
      end
      n_tests++;
      if (i0 !== exp_narrow(si) || q0 !== exp_narrow(sq)) begin
         n_fail++;
         $display("FAIL sat_values got=%0d/%0d want=%0d/%0d", i0, q0,
                  $signed(exp_narrow(si)), $signed(exp_narrow(sq)));
      end
      n_tests++;
      if (sat0 !== exp_sat(si, sq)) begin
         n_fail++;
         $display("FAIL sat_flag got=%b want=%b", sat0, exp_sat(si, sq));
      end
      repeat (3) step();
   endtask

   initial begin
      system_reset = 1'b0; trigger = 1'b0; adc_valid = 1'b0;
      adc_sample = '0; ref_cos = '0; ref_sin = '0;
      delay_len = '0; integ_len = '0;
      test_reset();
      test_basic();
      test_delay();
      test_retrigger();
      test_back_to_back();
      test_integ_zero();
      test_abort();
      test_random();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/iq_integrator.md
IQ_INTEGRATOR -- requirements
Module: iq_integrator

Interface
REQ-001 The module SHALL have parameter SAMPLE_W, default 16, signed width of ADC sample and reference inputs.
REQ-002 The module SHALL have parameter ACC_W, default 48, signed accumulator width.
REQ-003 The module SHALL have parameter SHIFT, default 16, arithmetic right shift applied to each accumulator before output.
REQ-004 The module SHALL have port clk100, input, 1, sole clock; all logic is on its rising edge.
REQ-005 The module SHALL have port system_reset, input, 1; reset is asynchronous and active-low.
REQ-006 The module SHALL have port trigger, input, 1, one-cycle readout-start strobe.
REQ-007 The module SHALL have port adc_valid, input, 1, qualifies adc_sample, ref_cos and ref_sin.
REQ-008 The module SHALL have port adc_sample, input, SAMPLE_W signed, digitized readout signal.
REQ-009 The module SHALL have ports ref_cos and ref_sin, input, SAMPLE_W signed each, demodulation references.
REQ-010 The module SHALL have port delay_len, input, 16, samples skipped after trigger.
REQ-011 The module SHALL have port integ_len, input, 16, samples integrated.
REQ-012 The module SHALL have port data_valid, output, 1, one-cycle strobe driving analyze_fsm data_in.
REQ-013 The module SHALL have ports i_val and q_val, output, 32 signed each, integrated quadratures feeding analyze_fsm.
REQ-014 The module SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-015 The module SHALL have port sat, output, 1, high when the last i_val or q_val result was clipped.

Function
REQ-016 The FSM SHALL have states IDLE, DELAY, INTEGRATE, DRAIN and OUTPUT.
REQ-017 In IDLE, trigger high SHALL latch delay_len and integ_len, clear both accumulators and the sample counter, and enter DELAY, or enter INTEGRATE when latched delay_len is 0.
REQ-018 Trigger while not in IDLE SHALL be ignored, with no effect on state, counters or outputs.
REQ-019 In DELAY, each adc_valid cycle SHALL increment the counter; on the delay_len-th sample the FSM SHALL zero the counter and enter INTEGRATE; that sample SHALL NOT be integrated.
REQ-020 In INTEGRATE, each adc_valid cycle SHALL register the products adc_sample*ref_cos and adc_sample*ref_sin (2*SAMPLE_W signed) in stage 1, then sign-extend and add them into I and Q accumulators (ACC_W) in stage 2.
REQ-021 Cycles with adc_valid low SHALL be skipped, advancing neither the counter nor the accumulators.
REQ-022 A latched integ_len of 0 SHALL be treated as 1.
REQ-023 On acceptance of the integ_len-th sample the FSM SHALL enter DRAIN and ignore adc_valid until the next IDLE.
REQ-024 DRAIN SHALL last until the final product is accumulated; the FSM SHALL then enter OUTPUT.
REQ-025 OUTPUT SHALL register i_val and q_val as accumulator >>> SHIFT, narrowed to 32 bits per REQ-031, pulse data_valid high for exactly one cycle, and return to IDLE.
REQ-026 data_valid SHALL rise at the 3rd rising edge after the edge that samples the last integrated sample.
REQ-027 i_val, q_val and sat SHALL hold their values until the next OUTPUT.
REQ-028 A trigger arriving in the same cycle that OUTPUT returns to IDLE SHALL be ignored; the earliest accepted trigger is the first cycle in IDLE.

Reset
REQ-029 While system_reset is low, the FSM SHALL be IDLE, and all counters, accumulators and product registers SHALL be 0.
REQ-030 While system_reset is low, data_valid, busy and sat SHALL be 0, and i_val and q_val SHALL be 0; reset asserted mid-integration SHALL discard that result with no data_valid pulse.

Configuration
REQ-031 With macro IQ_INTEGRATOR_SATURATE_EN defined, shifted results outside [-2^31, 2^31-1] SHALL clamp to the nearest bound and set sat; without the macro, results SHALL be truncated to the low 32 bits (wrap) and sat SHALL be tied to 0.

Verification
REQ-032 The bench SHALL cover: adc_sample=1000, ref_cos=16384, ref_sin=0, delay_len=0, integ_len=4, adc_valid continuous -> one data_valid pulse 3 edges after 4th sample; i_val=1000, q_val=0, sat=0.
REQ-033 The bench SHALL cover: same stimulus, delay_len=3, adc_valid toggling every other cycle, first 3 valid samples set to 30000 -> i_val=1000; delayed samples excluded.
REQ-034 The bench SHALL cover: SHIFT=0, adc_sample=32767, ref_cos=32767, ref_sin=-32768, integ_len=65535, macro defined -> i_val=2147483647, q_val=-2147483648, sat=1; macro undefined -> low 32 bits of the raw sums, sat=0.
REQ-035 The bench SHALL cover: a second trigger mid-INTEGRATE -> ignored, exactly one data_valid, result unchanged from REQ-032.
REQ-036 The bench SHALL cover: system_reset low after 2 of 4 samples, then released and re-triggered -> no pulse from the aborted run; the next run gives i_val=1000.
REQ-037 The bench SHALL cover: integ_len=0 with adc_sample=1000, ref_cos=16384 -> exactly one sample integrated; i_val=250, busy low after data_valid.
